// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the single memory port.
//   Port 0 is the mips core, port 1 is the program loader / debug DMA.
//   A granted requester may hold the port with pN_lock for up to MAX_HOLD
//   consecutive cycles while the other port waits (forever if the other is idle).
//   Read tags {valid, port} travel alongside the RD_LAT memory latency so each
//   read-valid returns to the port that issued it.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   pN_req/we/lock/adr/wdata    requester N access request and payload
//   pN_gnt                      combinational grant (access issued this cycle)
//   pN_rvalid                   read data valid for port N, qualifies rdata
//   rdata                       memory read data, passed through
//   mem_re/we/adr/wdata         memory command driven from the winner
//   mem_rdata                   memory read data, RD_LAT cycles after mem_re
module mem_port_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic             p0_lock,
    input  logic [WIDTH-1:0] p0_adr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic             p1_lock,
    input  logic [WIDTH-1:0] p1_adr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_re,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] HOLD_SAT = 4'd15;
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    logic              last_gnt_valid;
    logic              last_port;
    logic [3:0]        hold_cnt;
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_port;

    logic last_req;
    logic last_lock;
    logic other_req;
    logic lock_keep;
    logic win_valid;
    logic win_port;
    logic win_we;

    // Winner selection: lock first, then round-robin on contention.
    always_comb begin
        last_req  = last_port ? p1_req : p0_req;
        last_lock = last_port ? p1_lock : p0_lock;
        other_req = last_port ? p0_req : p1_req;
        lock_keep = last_gnt_valid && last_req && last_lock &&
                    ((hold_cnt < HOLD_LIM) || !other_req);
        win_valid = 1'b0;
        win_port  = 1'b0;
        if (!rst) begin
            if (lock_keep) begin
                win_valid = 1'b1;
                win_port  = last_port;
            end else if (p0_req && p1_req) begin
                win_valid = 1'b1;
                win_port  = ~last_port;
            end else if (p0_req) begin
                win_valid = 1'b1;
                win_port  = 1'b0;
            end else if (p1_req) begin
                win_valid = 1'b1;
                win_port  = 1'b1;
            end
        end
        win_we = win_port ? p1_we : p0_we;
    end

    // Grant and memory command mux; everything idles to zero with no winner.
    always_comb begin
        p0_gnt    = win_valid & ~win_port;
        p1_gnt    = win_valid & win_port;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        if (win_valid) begin
            mem_re    = ~win_we;
            mem_we    = win_we;
            mem_adr   = win_port ? p1_adr : p0_adr;
            mem_wdata = win_port ? p1_wdata : p0_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_valid <= 1'b0;
            last_port      <= 1'b1;
            hold_cnt       <= 4'd0;
            tag_valid      <= '0;
            tag_port       <= '0;
        end else begin
            last_gnt_valid <= win_valid;
            if (win_valid) begin
                last_port <= win_port;
            end
            if (!win_valid) begin
                hold_cnt <= 4'd0;
            end else if (!last_gnt_valid || (win_port != last_port)) begin
                hold_cnt <= 4'd1;
            end else if (hold_cnt != HOLD_SAT) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
            tag_valid[0] <= win_valid & ~win_we;
            tag_port[0]  <= win_port;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end
        end
    end

    // The last tag stage lines up with mem_rdata; masked while rst is high so a
    // read issued just before reset never reports valid.
    assign p0_rvalid = ~rst & tag_valid[RD_LAT-1] & ~tag_port[RD_LAT-1];
    assign p1_rvalid = ~rst & tag_valid[RD_LAT-1] & tag_port[RD_LAT-1];
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RD_LAT=1 and RD_LAT=3) share the
// same stimulus and are checked every cycle against a behavioural model that
// records which read was issued in which cycle and when resets happened.
module tb_mem_port_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req[2];
    logic       we[2];
    logic       lock[2];
    logic [7:0] adr[2];
    logic [7:0] wdata[2];
    logic [7:0] mem_rdata;

    logic       a_g0, a_g1, a_rv0, a_rv1, a_re, a_we;
    logic [7:0] a_adr, a_wd, a_rdata;
    logic       b_g0, b_g1, b_rv0, b_rv1, b_re, b_we;
    logic [7:0] b_adr, b_wd, b_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(8), .RD_LAT(1), .MAX_HOLD(MH)) dut_a (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lock[0]), .p0_adr(adr[0]),
        .p0_wdata(wdata[0]), .p0_gnt(a_g0), .p0_rvalid(a_rv0),
        .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lock[1]), .p1_adr(adr[1]),
        .p1_wdata(wdata[1]), .p1_gnt(a_g1), .p1_rvalid(a_rv1),
        .rdata(a_rdata), .mem_re(a_re), .mem_we(a_we), .mem_adr(a_adr),
        .mem_wdata(a_wd), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.WIDTH(8), .RD_LAT(3), .MAX_HOLD(MH)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lock[0]), .p0_adr(adr[0]),
        .p0_wdata(wdata[0]), .p0_gnt(b_g0), .p0_rvalid(b_rv0),
        .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lock[1]), .p1_adr(adr[1]),
        .p1_wdata(wdata[1]), .p1_gnt(b_g1), .p1_rvalid(b_rv1),
        .rdata(b_rdata), .mem_re(b_re), .mem_we(b_we), .mem_adr(b_adr),
        .mem_wdata(b_wd), .mem_rdata(mem_rdata)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    bit          m_valid = 1'b0;
    int          m_last  = 1;
    int          m_hold  = 0;
    int          cyc     = 0;
    int          last_rst_cyc = -100;
    bit          iss_v[4096];
    bit          iss_p[4096];
    bit          wv;
    int          wp;
    logic [59:0] exp_vec;
    logic [59:0] obs_vec;

    // A read issued in cycle s shows up at s+lat unless reset intervened.
    function automatic bit exp_rv(input int lat, input int port);
        int s;
        s = cyc - lat;
        if (rst) return 1'b0;
        if (s < 0) return 1'b0;
        if (last_rst_cyc >= s) return 1'b0;
        return iss_v[s] && (int'(iss_p[s]) == port);
    endfunction

    task automatic drive(input bit r0, input bit w0, input bit l0,
                         input bit r1, input bit w1, input bit l1, input bit rs);
        rst       = rs;
        req[0]    = r0;
        we[0]     = w0;
        lock[0]   = l0;
        req[1]    = r1;
        we[1]     = w1;
        lock[1]   = l1;
        adr[0]    = 8'($urandom());
        adr[1]    = 8'($urandom());
        wdata[0]  = 8'($urandom());
        wdata[1]  = 8'($urandom());
        mem_rdata = 8'($urandom());
    endtask

    // Mid-cycle: evaluate the model for the current inputs, sample the DUTs.
    task automatic settle();
        bit         keep;
        bit         g0, g1, re, mwe;
        logic [7:0] ma, md;
        @(negedge clk);
        if (rst) last_rst_cyc = cyc;
        wv = 1'b0;
        wp = 0;
        if (!rst) begin
            keep = m_valid && req[m_last] && lock[m_last] &&
                   (m_hold < MH || !req[1-m_last]);
            if (keep) begin
                wv = 1'b1; wp = m_last;
            end else if (req[0] && req[1]) begin
                wv = 1'b1; wp = 1 - m_last;
            end else if (req[0]) begin
                wv = 1'b1; wp = 0;
            end else if (req[1]) begin
                wv = 1'b1; wp = 1;
            end
        end
        g0  = wv && (wp == 0);
        g1  = wv && (wp == 1);
        re  = wv && !we[wp];
        mwe = wv && we[wp];
        ma  = wv ? adr[wp] : 8'h00;
        md  = wv ? wdata[wp] : 8'h00;
        iss_v[cyc] = wv && !we[wp];
        iss_p[cyc] = (wp == 1);
        exp_vec = {g0, g1, re, mwe, ma, md, exp_rv(1, 0), exp_rv(1, 1),
                   g0, g1, re, mwe, ma, md, exp_rv(3, 0), exp_rv(3, 1),
                   mem_rdata, mem_rdata};
        obs_vec = {a_g0, a_g1, a_re, a_we, a_adr, a_wd, a_rv0, a_rv1,
                   b_g0, b_g1, b_re, b_we, b_adr, b_wd, b_rv0, b_rv1,
                   a_rdata, b_rdata};
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_last = 1; m_hold = 0;
        end else begin
            if (!wv) m_hold = 0;
            else if (!m_valid || wp != m_last) m_hold = 1;
            else m_hold = (m_hold < 15) ? m_hold + 1 : 15;
            m_valid = wv;
            if (wv) m_last = wp;
        end
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        drive(1'($urandom()), 1'($urandom()), 1'b0, 1'($urandom()), 1'($urandom()), 1'b0, 1'b1);
        settle();
        advance();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom()), 1'($urandom()), 1'b1, 1'($urandom()), 1'($urandom()), 1'b1, 1'b1);
            settle();
            n_total++;
            if (obs_vec[59:16] !== 44'h0)
                $display("FAIL reset_outs cyc=%0d got=%h exp=0", cyc, obs_vec[59:16]);
            else n_pass++;
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        n_total++;
        if (obs_vec !== exp_vec) $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec);
        else n_pass++;
        advance();
    endtask

    task automatic test_single_read();
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        adr[0] = 8'h10;
        settle();
        n_total++;
        if ({a_g0, a_re, a_adr} !== {1'b1, 1'b1, 8'h10})
            $display("FAIL single_issue got=%b%b/%h exp=11/10", a_g0, a_re, a_adr);
        else n_pass++;
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_rdata = 8'hA5;
        settle();
        n_total++;
        if ({a_rv0, a_rv1, a_rdata} !== {1'b1, 1'b0, 8'hA5})
            $display("FAIL single_return got=%b%b/%h exp=10/a5", a_rv0, a_rv1, a_rdata);
        else n_pass++;
        n_total++;
        if (obs_vec !== exp_vec) $display("FAIL single_model got=%h exp=%h", obs_vec, exp_vec);
        else n_pass++;
        advance();
    endtask

    task automatic test_alternate();
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            settle();
            n_total++;
            if (a_g0 !== ((i % 2) == 0) || a_g1 !== ((i % 2) == 1))
                $display("FAIL alt_order i=%0d got=%b%b", i, a_g0, a_g1);
            else n_pass++;
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL alt_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_lock_burst();
        logic [9:0] seq;
        seq = '0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(i != 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            settle();
            seq = {seq[8:0], a_g1};
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL lock_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            else n_pass++;
            advance();
        end
        n_total++;
        if (seq !== 10'b1111011110) $display("FAIL lock_pattern got=%b exp=1111011110", seq);
        else n_pass++;
    endtask

    task automatic test_lock_idle();
        int n_list[2];
        int cnt;
        n_list[0] = 20;
        n_list[1] = 17;
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            cnt = 0;
            for (int i = 0; i < n_list[k]; i++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
                settle();
                if (a_g1 === 1'b1) cnt++;
                n_total++;
                if (obs_vec !== exp_vec) $display("FAIL idle_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
                else n_pass++;
                advance();
            end
            n_total++;
            if (cnt != n_list[k]) $display("FAIL idle_count got=%0d exp=%0d", cnt, n_list[k]);
            else n_pass++;
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            settle();
            n_total++;
            if ({a_g0, a_g1} !== 2'b10) $display("FAIL idle_takeover got=%b%b exp=10", a_g0, a_g1);
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] rv0s, rv1s;
        rv0s = '0;
        rv1s = '0;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                1:       drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                2:       drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                default: drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            endcase
            settle();
            rv0s = {rv0s[5:0], b_rv0};
            rv1s = {rv1s[5:0], b_rv1};
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL b2b_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            else n_pass++;
            advance();
        end
        n_total++;
        if ({rv0s, rv1s} !== {7'b0001000, 7'b0000100})
            $display("FAIL b2b_lat3 got=%b/%b exp=0001000/0000100", rv0s, rv1s);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        seen = 1'b0;
        apply_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        advance();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        n_total++;
        if (obs_vec[59:16] !== 44'h0) $display("FAIL midrst_outs got=%h exp=0", obs_vec[59:16]);
        else n_pass++;
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            settle();
            if (a_rv0 || b_rv0 || a_rv1 || b_rv1) seen = 1'b1;
            advance();
        end
        n_total++;
        if (seen) $display("FAIL midrst_rvalid got=1 exp=0");
        else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        n_total++;
        if ({a_g0, a_g1} !== 2'b10) $display("FAIL midrst_first got=%b%b exp=10", a_g0, a_g1);
        else n_pass++;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom()), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0), 1'($urandom()), 1'($urandom_range(0, 3) != 0),
                  $urandom_range(0, 29) == 0);
            settle();
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL rand_model i=%0d got=%h exp=%h", i, obs_vec, exp_vec);
            else n_pass++;
            advance();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_alternate();
        test_lock_burst();
        test_lock_idle();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
